pair_sort4_ctrl: RTL and testbench

- Compare-and-swap initiator. Collects a block of four WIDTH-bit words over a valid/ready input stream.
- Sorts the block in place with bubble-sort passes, issuing one compare-and-swap per clock.
- Returns the sorted block over a valid/ready output stream.
- Sits upstream of the byte-pair swap datapath as its control/ordering source. It also serves standalone as a small sorter in the training datapath.

---
 rtl/pair_sort4_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pair_sort4_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_sort4_ctrl.sv
// pair_sort4_ctrl
// Collects a block of four WIDTH-bit words over a valid/ready input stream,
// sorts it in place with bubble-sort passes (one compare-and-swap per clock),
// then returns the sorted block over a valid/ready output stream.
//
// Parameters:
//   WIDTH   - data word width in bits
//   DESCEND - 0: ascending (word 0 smallest), 1: descending
//
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   in_valid   - in_data holds a valid word
//   in_ready   - block can accept a word this cycle (LOAD)
//   in_data    - input word
//   out_valid  - out_data holds a valid sorted word (DRAIN)
//   out_ready  - downstream accepts out_data this cycle
//   out_data   - sorted word, driven from a register
//   out_last   - marks the 4th word of the block
//   busy       - high in SORT or DRAIN
//   swap_count - swaps performed on the current/last block (0..6)
module pair_sort4_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter logic        DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [2:0]       swap_count
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       j_q, j_d;
  logic [1:0]       pass_q, pass_d;
  logic             pass_swapped_q, pass_swapped_d;
  logic [2:0]       swap_count_q, swap_count_d;

  // Output registers, loaded from the next-state values so every output
  // comes straight from a flop.
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] lo_s, hi_s;
  logic             swap_s;
  logic             swapped_any_s;

  // Strict comparison, so equal words never swap (stable sort).
  function automatic logic need_swap(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    if (DESCEND) begin
      need_swap = (a < b);
    end else begin
      need_swap = (a > b);
    end
  endfunction

  // Next-state logic: load, compare-and-swap sequencing and drain.
  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    idx_d          = idx_q;
    j_d            = j_q;
    pass_d         = pass_q;
    pass_swapped_d = pass_swapped_q;
    swap_count_d   = swap_count_q;
    lo_s           = buf_q[j_q];
    hi_s           = buf_q[j_q + 2'd1];
    swap_s         = 1'b0;
    swapped_any_s  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          buf_d[idx_q] = in_data;
          idx_d        = idx_q + 2'd1;
          if (idx_q == 2'd0) begin
            swap_count_d = 3'd0;
          end else begin
            swap_count_d = swap_count_q;
          end
          if (idx_q == 2'd3) begin
            idx_d          = 2'd0;
            j_d            = 2'd0;
            pass_d         = 2'd0;
            pass_swapped_d = 1'b0;
            state_d        = ST_SORT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_SORT: begin
        swap_s = need_swap(lo_s, hi_s);
        if (swap_s) begin
          buf_d[j_q]        = hi_s;
          buf_d[j_q + 2'd1] = lo_s;
          swap_count_d      = swap_count_q + 3'd1;
          pass_swapped_d    = 1'b1;
        end else begin
          swap_count_d = swap_count_q;
        end
        // A swap on the last compare of a pass still counts for that pass.
        swapped_any_s = pass_swapped_q | swap_s;
        if (j_q == 2'd2) begin
          if (!swapped_any_s || (pass_q == 2'd2)) begin
            state_d = ST_DRAIN;
          end else begin
            pass_d         = pass_q + 2'd1;
            j_d            = 2'd0;
            pass_swapped_d = 1'b0;
          end
        end else begin
          j_d = j_q + 2'd1;
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end

      default: begin
        state_d = ST_LOAD;
        idx_d   = 2'd0;
      end
    endcase

    in_ready_d  = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_DRAIN);
    busy_d      = (state_d != ST_LOAD);
    out_data_d  = buf_d[idx_d];
    out_last_d  = (state_d == ST_DRAIN) && (idx_d == 2'd3);
  end

  // Control state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_LOAD;
      idx_q          <= 2'd0;
      j_q            <= 2'd0;
      pass_q         <= 2'd0;
      pass_swapped_q <= 1'b0;
      swap_count_q   <= 3'd0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      busy_q         <= 1'b0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      j_q            <= j_d;
      pass_q         <= pass_d;
      pass_swapped_q <= pass_swapped_d;
      swap_count_q   <= swap_count_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      busy_q         <= busy_d;
      out_data_q     <= out_data_d;
    end
  end

  // Word storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign out_data   = out_data_q;
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_pair_sort4_ctrl.sv
module tb_pair_sort4_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, out_ready, sel;
  logic [7:0] in_data;

  logic       in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [7:0] out_data_a;
  logic [2:0] swap_count_a;
  logic       in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [7:0] out_data_d;
  logic [2:0] swap_count_d;

  // sel = 0 routes traffic to the ascending build, 1 to the descending build
  pair_sort4_ctrl #(.WIDTH(8), .DESCEND(1'b0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready & ~sel),
    .out_data(out_data_a), .out_last(out_last_a),
    .busy(busy_a), .swap_count(swap_count_a)
  );

  pair_sort4_ctrl #(.WIDTH(8), .DESCEND(1'b1)) dut_desc (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & sel), .in_ready(in_ready_d), .in_data(in_data),
    .out_valid(out_valid_d), .out_ready(out_ready & sel),
    .out_data(out_data_d), .out_last(out_last_d),
    .busy(busy_d), .swap_count(swap_count_d)
  );

  logic       in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [7:0] out_data_m;
  logic [2:0] swap_count_m;
  assign in_ready_m   = sel ? in_ready_d   : in_ready_a;
  assign out_valid_m  = sel ? out_valid_d  : out_valid_a;
  assign out_last_m   = sel ? out_last_d   : out_last_a;
  assign busy_m       = sel ? busy_d       : busy_a;
  assign out_data_m   = sel ? out_data_d   : out_data_a;
  assign swap_count_m = sel ? swap_count_d : swap_count_a;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] w0, input logic [7:0] w1,
                                        input logic [7:0] w2, input logic [7:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [7:0] wd(input logic [31:0] b, input int i);
    return b[8*i +: 8];
  endfunction

  // Reference: stable rank placement, swaps = inversion count, and the
  // number of passes from the furthest leftward move any word must make
  // (bubble sort moves a word left by at most one place per pass).
  task automatic model(input logic [31:0] blk, input logic desc,
                       output logic [31:0] sorted, output int swaps, output int cyc);
    logic [7:0] a [4];
    int rank, left, k;
    bit goes_before, out_of_order;
    for (int i = 0; i < 4; i++) a[i] = wd(blk, i);
    sorted = 32'd0; swaps = 0; k = 0;
    for (int i = 0; i < 4; i++) begin
      rank = 0; left = 0;
      for (int j = 0; j < 4; j++) begin
        if (j != i) begin
          goes_before  = desc ? (a[j] > a[i]) : (a[j] < a[i]);
          out_of_order = desc ? (a[j] < a[i]) : (a[j] > a[i]);
          if (goes_before || (a[j] == a[i] && j < i)) rank++;
          if (j < i && out_of_order) left++;
        end
      end
      sorted[8*rank +: 8] = a[i];
      swaps += left;
      if (left > k) k = left;
    end
    cyc = 3 * ((k + 1 > 3) ? 3 : k + 1);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send_block(input string tag, input logic [31:0] blk, input bit gaps);
    int i = 0;
    int guard = 0;
    logic rdy;
    while (i < 4 && guard < 200) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end else begin
        in_valid = 1'b1;
        in_data  = wd(blk, i);
        rdy      = in_ready_m;
        @(negedge clk);
        if (rdy) i++;
      end
      guard++;
    end
    in_valid = 1'b0;
    chk(tag, "words_accepted", i, 4);
  endtask

  task automatic wait_sort(input string tag, input int exp_cyc);
    int cyc = 0;
    while (!out_valid_m && cyc < 50) begin
      chk(tag, "busy_in_sort", busy_m, 1);
      chk(tag, "in_ready_in_sort", in_ready_m, 0);
      cyc++;
      @(negedge clk);
    end
    chk(tag, "sort_cycles", cyc, exp_cyc);
  endtask

  task automatic recv_block(input string tag, input logic [31:0] exp, input int exp_swaps,
                            input logic [15:0] pat, input int patlen, input bit rnd);
    int k = 0;
    int cyc = 0;
    logic r, v;
    while (k < 4 && cyc < 200) begin
      chk(tag, "out_valid", out_valid_m, 1);
      chk(tag, "out_data", out_data_m, wd(exp, k));
      chk(tag, "out_last", out_last_m, (k == 3));
      chk(tag, "busy_in_drain", busy_m, 1);
      chk(tag, "in_ready_in_drain", in_ready_m, 0);
      chk(tag, "swap_count", swap_count_m, exp_swaps);
      if (rnd) r = 1'($urandom_range(0, 1));
      else if (cyc < patlen) r = pat[cyc];
      else r = 1'b1;
      v = out_valid_m;
      out_ready = r;
      @(negedge clk);
      if (r && v) k++;
      cyc++;
    end
    out_ready = 1'b0;
    chk(tag, "transfers", k, 4);
    chk(tag, "in_ready_after", in_ready_m, 1);
    chk(tag, "out_valid_after", out_valid_m, 0);
    chk(tag, "busy_after", busy_m, 0);
    chk(tag, "swap_count_held", swap_count_m, exp_swaps);
  endtask

  typedef struct {
    string       tag;
    logic        sel;
    logic [31:0] blk;
    logic [31:0] exp;
    int          swaps;
    int          cyc;
    logic [15:0] pat;
    int          patlen;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [31:0] blk, exp_sorted;
    int exp_swaps, exp_cyc;

    vecs[0] = '{"ascending", 1'b0, pack4(8'h01, 8'h02, 8'h03, 8'h04),
                pack4(8'h01, 8'h02, 8'h03, 8'h04), 0, 3, 16'h0000, 0};
    vecs[1] = '{"reversed", 1'b0, pack4(8'h40, 8'h30, 8'h20, 8'h10),
                pack4(8'h10, 8'h20, 8'h30, 8'h40), 6, 9, 16'h0000, 0};
    vecs[2] = '{"duplicates", 1'b0, pack4(8'h05, 8'h05, 8'h02, 8'h05),
                pack4(8'h02, 8'h05, 8'h05, 8'h05), 2, 9, 16'h0000, 0};
    // out_ready per drain cycle: 1,0,0,1,0,1,1
    vecs[3] = '{"backpressure", 1'b0, pack4(8'h40, 8'h30, 8'h20, 8'h10),
                pack4(8'h10, 8'h20, 8'h30, 8'h40), 6, 9, 16'b0000000001101001, 7};
    // swapped pairs under bubble sort: (10,FF), (00,80), (10,80)
    vecs[4] = '{"descend", 1'b1, pack4(8'h10, 8'hFF, 8'h00, 8'h80),
                pack4(8'hFF, 8'h80, 8'h10, 8'h00), 3, 9, 16'h0000, 0};

    sel = 1'b0; reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", "in_ready_asc", in_ready_a, 1);
    chk("reset", "out_valid_asc", out_valid_a, 0);
    chk("reset", "out_last_asc", out_last_a, 0);
    chk("reset", "busy_asc", busy_a, 0);
    chk("reset", "swap_count_asc", swap_count_a, 0);
    chk("reset", "in_ready_desc", in_ready_d, 1);
    chk("reset", "out_valid_desc", out_valid_d, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      sel = vecs[v].sel;
      send_block(vecs[v].tag, vecs[v].blk, 1'b0);
      wait_sort(vecs[v].tag, vecs[v].cyc);
      recv_block(vecs[v].tag, vecs[v].exp, vecs[v].swaps, vecs[v].pat, vecs[v].patlen, 1'b0);
      @(negedge clk);
    end

    // Reset on the 5th SORT cycle of a reversed block.
    sel = 1'b0;
    send_block("midsort", pack4(8'h40, 8'h30, 8'h20, 8'h10), 1'b0);
    repeat (4) @(negedge clk);
    chk("midsort", "swaps_before_reset", swap_count_a, 4);
    chk("midsort", "busy_before_reset", busy_a, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midsort", "in_ready", in_ready_a, 1);
    chk("midsort", "out_valid", out_valid_a, 0);
    chk("midsort", "busy", busy_a, 0);
    chk("midsort", "swap_count", swap_count_a, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midsort", "no_emit", out_valid_a, 0);
    end
    send_block("after_reset", pack4(8'h09, 8'h07, 8'h08, 8'h06), 1'b0);
    wait_sort("after_reset", 9);
    recv_block("after_reset", pack4(8'h06, 8'h07, 8'h08, 8'h09), 5, 16'h0000, 0, 1'b0);

    // Randomized blocks against the reference model.
    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom_range(0, 1));
      for (int w = 0; w < 4; w++)
        blk[8*w +: 8] = (n % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      model(blk, sel, exp_sorted, exp_swaps, exp_cyc);
      send_block("random", blk, 1'b1);
      wait_sort("random", exp_cyc);
      recv_block("random", exp_sorted, exp_swaps, 16'h0000, 0, 1'b1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
